// File: rtl/fifo_pkg.sv
// Shared defaults and sizing helpers for the single-clock FIFO.
package fifo_pkg;

   localparam int DEFAULT_DATA_WIDTH = 8;
   localparam int DEFAULT_DEPTH      = 16;

   // Pointer width for a power-of-two depth; the occupancy counter needs one more bit.
   function automatic int ptr_width(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: synchronous write, registered read data.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int DEPTH      = DEFAULT_DEPTH,
   localparam int AW        = ptr_width(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_i,
   input  logic                  we_i,
   input  logic [AW-1:0]         waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  re_i,
   input  logic [AW-1:0]         raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   // NOTE: the array is deliberately left out of reset; stale entries are unreachable
   // once the pointers and count clear, and a resettable array costs a mux per bit.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_dut.sv
// Single-clock FIFO: pointer, occupancy and flag control around a fifo_mem array.
module fifo_dut
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int DEPTH      = DEFAULT_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wen,
   input  logic                  ren,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  full,
   output logic                  empty
);

   localparam int AW = ptr_width(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("fifo_dut: DEPTH must be a power of two and at least 2");
   end

   // rst_n keeps its legacy name but is an active-high synchronous reset.
   logic rst;
   assign rst = rst_n;

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q,  count_d;
   logic          do_wr, do_rd;

   assign empty = (count_q == '0);
   assign full  = (count_q == COUNT_FULL);

   // A read frees a slot in the same cycle, so a full FIFO still accepts a paired write.
   assign do_rd = ren && !empty;
   assign do_wr = wen && (!full || do_rd);

   // NOTE: every next-state signal gets a default first so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_wr) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (do_rd) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      unique case ({do_wr, do_rd})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_mem (
      .clk     (clk),
      .rst_i   (rst),
      .we_i    (do_wr),
      .waddr_i (wr_ptr_q),
      .wdata_i (din),
      .re_i    (do_rd),
      .raddr_i (rd_ptr_q),
      .rdata_o (dout)
   );

endmodule

// File: tb/tb_fifo_dut.sv
// Directed bench for fifo_dut: queue-based reference model plus hand-computed expectations.
module tb_fifo_dut;

   localparam int DW    = 8;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          wen = 1'b0;
   logic          ren = 1'b0;
   logic [DW-1:0] din = '0;
   logic [DW-1:0] dout;
   logic          full;
   logic          empty;

   int checks_total = 0;
   int checks_pass  = 0;

   fifo_dut #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .wen   (wen),
      .ren   (ren),
      .din   (din),
      .dout  (dout),
      .full  (full),
      .empty (empty)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks_total++;
      if (act === exp) begin
         checks_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of held entries and the last value read out.
   logic [DW-1:0] model_q[$];
   logic [DW-1:0] model_dout = '0;
   bit            model_valid = 1'b0;
   bit            m_rd, m_wr;

   always @(posedge clk) begin
      if (rst_n) begin
         model_q.delete();
         model_dout  = '0;
         model_valid = 1'b1;
      end else begin
         m_rd = ren && (model_q.size() > 0);
         m_wr = wen && ((model_q.size() < DEPTH) || m_rd);
         if (m_rd) model_dout = model_q.pop_front();
         if (m_wr) model_q.push_back(din);
      end
   end

   always @(negedge clk) begin
      if (model_valid) begin
         check("model_dout",  32'(dout),  32'(model_dout));
         check("model_empty", 32'(empty), 32'(model_q.size() == 0));
         check("model_full",  32'(full),  32'(model_q.size() == DEPTH));
      end
   end

   // One clock: drive at the falling edge, return just after the rising edge.
   task automatic step(input logic r, input logic w, input logic rd, input logic [DW-1:0] d);
      @(negedge clk);
      rst_n = r;
      wen   = w;
      ren   = rd;
      din   = d;
      @(posedge clk);
      #1;
   endtask

   task automatic fill_seq(input int first);
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, DW'(first + i));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] exp_rd;
      logic [DW-1:0] wr_val;

      // Reset held for 5 cycles, then idle
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, '0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_full",  32'(full),  32'd0);
      check("rst_dout",  32'(dout),  32'h0);
      step(1'b0, 1'b0, 1'b0, '0);
      step(1'b0, 1'b0, 1'b0, '0);
      check("idle_empty", 32'(empty), 32'd1);
      check("idle_full",  32'(full),  32'd0);

      // Fill with 0x01..0x10 and drain
      fill_seq(1);
      check("fill_full",  32'(full),  32'd1);
      check("fill_empty", 32'(empty), 32'd0);
      for (int i = 1; i <= DEPTH; i++) begin
         step(1'b0, 1'b0, 1'b1, '0);
         check("drain_dout", 32'(dout), 32'(i));
      end
      check("drain_empty", 32'(empty), 32'd1);

      // Overflow: write while full with no read is dropped
      fill_seq(1);
      step(1'b0, 1'b1, 1'b0, 8'hAA);
      check("ovf_full", 32'(full), 32'd1);
      for (int i = 1; i <= DEPTH; i++) begin
         step(1'b0, 1'b0, 1'b1, '0);
         check("ovf_dout", 32'(dout), 32'(i));
      end
      check("ovf_empty", 32'(empty), 32'd1);

      // Underflow: reads while empty leave dout at 0x10
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'b1, '0);
         check("unf_dout",  32'(dout),  32'h10);
         check("unf_empty", 32'(empty), 32'd1);
      end

      // Simultaneous read/write while full
      fill_seq(1);
      step(1'b0, 1'b1, 1'b1, 8'h55);
      check("rw_full_dout", 32'(dout), 32'h01);
      check("rw_full_full", 32'(full), 32'd1);
      for (int i = 2; i <= DEPTH; i++) begin
         step(1'b0, 1'b0, 1'b1, '0);
         check("rw_full_drain", 32'(dout), 32'(i));
      end
      step(1'b0, 1'b0, 1'b1, '0);
      check("rw_full_last", 32'(dout), 32'h55);

      // Simultaneous read/write while empty: write only, no fall-through
      step(1'b0, 1'b1, 1'b1, 8'h77);
      check("rw_empty_empty", 32'(empty), 32'd0);
      check("rw_empty_dout",  32'(dout),  32'h55);
      step(1'b0, 1'b0, 1'b1, '0);
      check("rw_empty_read", 32'(dout), 32'h77);

      // Wrap-around: prefill 10, then interleave both / write-only / read-only
      wr_val = 8'h20;
      exp_rd = 8'h20;
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b1, 1'b0, wr_val);
         wr_val++;
      end
      for (int i = 0; i < 40; i++) begin
         case (i % 3)
            0: begin
               step(1'b0, 1'b1, 1'b1, wr_val);
               wr_val++;
               check("wrap_dout", 32'(dout), 32'(exp_rd));
               exp_rd++;
            end
            1: begin
               step(1'b0, 1'b1, 1'b0, wr_val);
               wr_val++;
            end
            default: begin
               step(1'b0, 1'b0, 1'b1, '0);
               check("wrap_dout", 32'(dout), 32'(exp_rd));
               exp_rd++;
            end
         endcase
      end
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0, 1'b1, '0);
         check("wrap_tail", 32'(dout), 32'(exp_rd));
         exp_rd++;
      end
      check("wrap_not_empty", 32'(empty), 32'd0);

      // Mid-operation reset with 5 entries held; reset wins over wen/ren
      step(1'b1, 1'b1, 1'b1, 8'hEE);
      check("mid_rst_empty", 32'(empty), 32'd1);
      check("mid_rst_dout",  32'(dout),  32'h0);
      step(1'b0, 1'b1, 1'b0, 8'h99);
      step(1'b0, 1'b0, 1'b1, '0);
      check("post_rst_read",  32'(dout),  32'h99);
      check("post_rst_empty", 32'(empty), 32'd1);

      step(1'b0, 1'b0, 1'b0, '0);
      @(negedge clk);
      $display("%0d/%0d checks passed", checks_pass, checks_total);
      $finish;
   end

endmodule
